// File: rtl/branch_predictor_if.sv
`default_nettype none
// ============================================================================
// Module      : branch_predictor_if
// Description : Fetch/Execute-side bundle of the branch predictor.
//               master  = pipeline (drives PCs and resolved outcomes)
//               slave   = branch_predictor (drives predictions, redirect
//                         and statistics)
//   PCF          fetch PC                  PredTakenF/PredPCF  prediction
//   UpdateE..    resolved branch/jump      MispredictE/RedirectPCE
//   FlushAll     table invalidate          BranchCount/MispredCount
// Revision    : 1.0  initial release
// ============================================================================
interface branch_predictor_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
);
    logic [XLEN-1:0]  PCF;
    logic             PredTakenF;
    logic [XLEN-1:0]  PredPCF;
    logic             UpdateE;
    logic [XLEN-1:0]  PCE;
    logic             JumpE;
    logic             TakenE;
    logic [XLEN-1:0]  TargetE;
    logic             PredTakenE;
    logic [XLEN-1:0]  PredPCE;
    logic             FlushAll;
    logic             MispredictE;
    logic [XLEN-1:0]  RedirectPCE;
    logic [CNT_W-1:0] BranchCount;
    logic [CNT_W-1:0] MispredCount;

    modport master (
        output PCF, UpdateE, PCE, JumpE, TakenE, TargetE, PredTakenE, PredPCE, FlushAll,
        input  PredTakenF, PredPCF, MispredictE, RedirectPCE, BranchCount, MispredCount
    );

    modport slave (
        input  PCF, UpdateE, PCE, JumpE, TakenE, TargetE, PredTakenE, PredPCE, FlushAll,
        output PredTakenF, PredPCF, MispredictE, RedirectPCE, BranchCount, MispredCount
    );
endinterface
`default_nettype wire

// File: rtl/branch_predictor.sv
`default_nettype none
// ============================================================================
// Module      : branch_predictor
// Description : Direct-mapped branch predictor + BTB. Each entry holds a
//               valid bit, tag, target, 2-bit saturating counter and an
//               unconditional-jump flag. Lookup from PCF is combinational;
//               Execute reports resolved branches, which update the table on
//               the rising edge and are checked for misprediction.
// Ports       : clk    rising-edge clock
//               reset  asynchronous active-high reset
//               bus    branch_predictor_if.slave (see interface header)
// Revision    : 1.0  initial release
// ============================================================================
module branch_predictor #(
    parameter int         XLEN     = 32,
    parameter int         ENTRIES  = 16,
    parameter logic [1:0] CTR_INIT = 2'b01,
    parameter int         CNT_W    = 32
) (
    input  wire logic          clk,
    input  wire logic          reset,
    branch_predictor_if.slave  bus
);

    localparam int              IDX_W     = $clog2(ENTRIES);
    localparam int              TAG_W     = XLEN - IDX_W - 2;
    localparam logic [XLEN-1:0] c_pc_step = XLEN'(4);

    generate
        if ((ENTRIES < 2) || ((ENTRIES & (ENTRIES - 1)) != 0)) begin : g_bad_entries
            $error("branch_predictor: ENTRIES must be a power of two >= 2");
        end
    endgenerate

    // ------------------------------------------------------------------
    // Table storage
    // ------------------------------------------------------------------
    logic             r_valid  [ENTRIES];
    logic [TAG_W-1:0] r_tag    [ENTRIES];
    logic [XLEN-1:0]  r_target [ENTRIES];
    logic [1:0]       r_ctr    [ENTRIES];
    logic             r_isjump [ENTRIES];

    logic [CNT_W-1:0] r_branch_cnt;
    logic [CNT_W-1:0] r_mispred_cnt;

    // ------------------------------------------------------------------
    // Fetch lookup (reads pre-update contents; no write bypass)
    // ------------------------------------------------------------------
    logic [IDX_W-1:0] w_f_idx;
    logic [TAG_W-1:0] w_f_tag;
    logic             w_f_hit;
    logic             w_f_taken;

    assign w_f_idx   = bus.PCF[IDX_W+1:2];
    assign w_f_tag   = bus.PCF[XLEN-1:IDX_W+2];
    assign w_f_hit   = r_valid[w_f_idx] && (r_tag[w_f_idx] == w_f_tag);
    assign w_f_taken = w_f_hit && (r_isjump[w_f_idx] || r_ctr[w_f_idx][1]);

    assign bus.PredTakenF = w_f_taken;
    assign bus.PredPCF    = w_f_taken ? r_target[w_f_idx] : bus.PCF + c_pc_step;

    // ------------------------------------------------------------------
    // Execute resolution
    // ------------------------------------------------------------------
    logic [IDX_W-1:0] w_e_idx;
    logic [TAG_W-1:0] w_e_tag;
    logic             w_e_hit;
    logic [XLEN-1:0]  w_e_pc_plus4;
    logic             w_mispredict;
    logic [1:0]       w_ctr_inc;
    logic [1:0]       w_ctr_dec;

    assign w_e_idx      = bus.PCE[IDX_W+1:2];
    assign w_e_tag      = bus.PCE[XLEN-1:IDX_W+2];
    assign w_e_hit      = r_valid[w_e_idx] && (r_tag[w_e_idx] == w_e_tag);
    assign w_e_pc_plus4 = bus.PCE + c_pc_step;

    // A taken prediction is only correct if the predicted target also matches.
    assign w_mispredict = bus.UpdateE &&
                          ((bus.PredTakenE != bus.TakenE) ||
                           (bus.TakenE && (bus.PredPCE != bus.TargetE)));

    assign bus.MispredictE = w_mispredict;
    assign bus.RedirectPCE = (bus.UpdateE && bus.TakenE) ? bus.TargetE : w_e_pc_plus4;

    assign w_ctr_inc = (r_ctr[w_e_idx] == 2'b11) ? 2'b11 : r_ctr[w_e_idx] + 2'b01;
    assign w_ctr_dec = (r_ctr[w_e_idx] == 2'b00) ? 2'b00 : r_ctr[w_e_idx] - 2'b01;

    // ------------------------------------------------------------------
    // Table update: reset > FlushAll > update
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_valid[i]  <= 1'b0;
                r_tag[i]    <= '0;
                r_target[i] <= '0;
                r_ctr[i]    <= CTR_INIT;
                r_isjump[i] <= 1'b0;
            end
        end else if (bus.FlushAll) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_valid[i] <= 1'b0;
                r_ctr[i]   <= CTR_INIT;
            end
        end else if (bus.UpdateE) begin
            if (w_e_hit) begin
                r_isjump[w_e_idx] <= bus.JumpE;
                if (bus.TakenE) begin
                    r_ctr[w_e_idx]    <= w_ctr_inc;
                    r_target[w_e_idx] <= bus.TargetE;
                end else begin
                    r_ctr[w_e_idx]    <= w_ctr_dec;
                end
            end else if (bus.TakenE) begin
                // Only taken misses allocate; not-taken misses leave the
                // resident (possibly aliasing) entry untouched.
                r_valid[w_e_idx]  <= 1'b1;
                r_tag[w_e_idx]    <= w_e_tag;
                r_target[w_e_idx] <= bus.TargetE;
                r_isjump[w_e_idx] <= bus.JumpE;
                r_ctr[w_e_idx]    <= bus.JumpE ? 2'b11 : 2'b10;
            end
        end
    end

    // ------------------------------------------------------------------
    // Statistics: saturating, counted even when a flush drops the write
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_branch_cnt  <= '0;
            r_mispred_cnt <= '0;
        end else if (bus.UpdateE) begin
            if (r_branch_cnt != '1) begin
                r_branch_cnt <= r_branch_cnt + CNT_W'(1);
            end
            if (w_mispredict && (r_mispred_cnt != '1)) begin
                r_mispred_cnt <= r_mispred_cnt + CNT_W'(1);
            end
        end
    end

    assign bus.BranchCount  = r_branch_cnt;
    assign bus.MispredCount = r_mispred_cnt;

endmodule
`default_nettype wire

// File: tb/tb_branch_predictor.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_predictor
// Description : Self-checking bench for branch_predictor. Directed steps
//               followed by randomized traffic compared against a
//               behavioural table model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_branch_predictor;

    localparam int XLEN    = 32;
    localparam int ENTRIES = 16;
    localparam int CNT_W   = 7;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    branch_predictor_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();

    branch_predictor #(
        .XLEN    (XLEN),
        .ENTRIES (ENTRIES),
        .CTR_INIT(2'b01),
        .CNT_W   (CNT_W)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    // ------------------------------------------------------------------
    // Behavioural model: one record per table slot, counter as an int
    // ------------------------------------------------------------------
    bit          m_valid  [ENTRIES];
    int unsigned m_tag    [ENTRIES];
    logic [31:0] m_target [ENTRIES];
    int          m_ctr    [ENTRIES];
    bit          m_jump   [ENTRIES];
    int          m_branch;
    int          m_mispred;

    int n_checks = 0;
    int n_pass   = 0;

    function automatic int unsigned idx_of(input logic [31:0] pc);
        return (pc / 4) % ENTRIES;
    endfunction

    function automatic int unsigned tag_of(input logic [31:0] pc);
        return pc / (4 * ENTRIES);
    endfunction

    function automatic bit model_hit(input logic [31:0] pc);
        return m_valid[idx_of(pc)] && (m_tag[idx_of(pc)] == tag_of(pc));
    endfunction

    task automatic model_reset();
        for (int i = 0; i < ENTRIES; i++) begin
            m_valid[i] = 0; m_tag[i] = 0; m_target[i] = '0; m_ctr[i] = 1; m_jump[i] = 0;
        end
        m_branch  = 0;
        m_mispred = 0;
    endtask

    task automatic model_predict(input logic [31:0] pc, output bit t, output logic [31:0] npc);
        int unsigned i;
        i   = idx_of(pc);
        t   = model_hit(pc) && (m_jump[i] || (m_ctr[i] >= 2));
        npc = t ? m_target[i] : pc + 32'd4;
    endtask

    task automatic model_update(input bit upd, input logic [31:0] pc, input bit taken,
                                input bit jump, input logic [31:0] tgt, input bit mis,
                                input bit flush);
        int unsigned i;
        i = idx_of(pc);
        if (upd) begin
            if (m_branch < CNT_MAX) m_branch++;
            if (mis && (m_mispred < CNT_MAX)) m_mispred++;
        end
        if (flush) begin
            for (int k = 0; k < ENTRIES; k++) begin
                m_valid[k] = 0;
                m_ctr[k]   = 1;
            end
        end else if (upd) begin
            if (model_hit(pc)) begin
                m_jump[i] = jump;
                if (taken) begin
                    m_ctr[i]    = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
                    m_target[i] = tgt;
                end else begin
                    m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
                end
            end else if (taken) begin
                m_valid[i]  = 1;
                m_tag[i]    = tag_of(pc);
                m_target[i] = tgt;
                m_jump[i]   = jump;
                m_ctr[i]    = jump ? 3 : 2;
            end
        end
    endtask

    // ------------------------------------------------------------------
    // Checking and stimulus helpers
    // ------------------------------------------------------------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // One clock: drive at negedge, check combinational outputs, clock, update model.
    task automatic cycle(input logic [31:0] pcf, input bit upd, input logic [31:0] pce,
                         input bit taken, input bit jump, input logic [31:0] tgt,
                         input bit ptaken, input logic [31:0] ppc, input bit flush,
                         output bit mis_o, output logic [31:0] redir_o);
        bit          et, emis;
        logic [31:0] epc, eredir;
        bus.PCF = pcf; bus.UpdateE = upd; bus.PCE = pce; bus.TakenE = taken;
        bus.JumpE = jump; bus.TargetE = tgt; bus.PredTakenE = ptaken;
        bus.PredPCE = ppc; bus.FlushAll = flush;
        #1;
        model_predict(pcf, et, epc);
        emis   = upd && ((ptaken != taken) || (taken && (ppc != tgt)));
        eredir = (upd && taken) ? tgt : pce + 32'd4;
        check("PredTakenF",   bus.PredTakenF,   et);
        check("PredPCF",      bus.PredPCF,      epc);
        check("MispredictE",  bus.MispredictE,  emis);
        check("RedirectPCE",  bus.RedirectPCE,  eredir);
        check("BranchCount",  bus.BranchCount,  m_branch);
        check("MispredCount", bus.MispredCount, m_mispred);
        mis_o   = bus.MispredictE;
        redir_o = bus.RedirectPCE;
        @(posedge clk);
        model_update(upd, pce, taken, jump, tgt, emis, flush);
        @(negedge clk);
    endtask

    // Resolve a branch at pce using the model's prediction as the piped one.
    task automatic resolve(input logic [31:0] pce, input bit taken, input bit jump,
                           input logic [31:0] tgt, output bit mis_o, output logic [31:0] redir_o);
        bit          pt;
        logic [31:0] pp;
        model_predict(pce, pt, pp);
        cycle(pce, 1'b1, pce, taken, jump, tgt, pt, pp, 1'b0, mis_o, redir_o);
    endtask

    // Idle lookup checked against fixed expectations.
    task automatic look(input string tag, input logic [31:0] pc, input bit t, input logic [31:0] npc);
        bus.PCF = pc; bus.UpdateE = 1'b0; bus.FlushAll = 1'b0;
        #1;
        check({tag, ".taken"}, bus.PredTakenF, t);
        check({tag, ".pc"},    bus.PredPCF,    npc);
        @(negedge clk);
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        bit          mis;
        logic [31:0] redir;
        int          bc_before;

        bus.PCF = '0; bus.UpdateE = 0; bus.PCE = '0; bus.JumpE = 0; bus.TakenE = 0;
        bus.TargetE = '0; bus.PredTakenE = 0; bus.PredPCE = '0; bus.FlushAll = 0;
        reset = 1'b0;
        #1 reset = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Reset state
        look("reset_lookup", 32'h100, 1'b0, 32'h104);
        check("reset_branch_cnt",  bus.BranchCount,  0);
        check("reset_mispred_cnt", bus.MispredCount, 0);
        look("wrap_pc4", 32'hFFFF_FFFC, 1'b0, 32'h0);

        // First taken branch: miss, mispredicted, allocated with ctr=10
        cycle(32'h0, 1'b1, 32'h100, 1'b1, 1'b0, 32'h80, 1'b0, 32'h104, 1'b0, mis, redir);
        check("first_mispredict", mis, 1'b1);
        check("first_redirect",   redir, 32'h80);
        look("after_alloc", 32'h100, 1'b1, 32'h80);

        // Not-taken x3: 01, 00, 00
        resolve(32'h100, 1'b0, 1'b0, 32'h0, mis, redir);
        look("nt1", 32'h100, 1'b0, 32'h104);
        resolve(32'h100, 1'b0, 1'b0, 32'h0, mis, redir);
        resolve(32'h100, 1'b0, 1'b0, 32'h0, mis, redir);
        // Taken x4: 01 (still not taken), 10, 11, 11
        resolve(32'h100, 1'b1, 1'b0, 32'h80, mis, redir);
        look("t1_from_sat0", 32'h100, 1'b0, 32'h104);
        resolve(32'h100, 1'b1, 1'b0, 32'h80, mis, redir);
        look("t2", 32'h100, 1'b1, 32'h80);
        resolve(32'h100, 1'b1, 1'b0, 32'h80, mis, redir);
        resolve(32'h100, 1'b1, 1'b0, 32'h80, mis, redir);
        // From 11, two not-taken leave 01 -> not taken (proves saturation at 11)
        resolve(32'h100, 1'b0, 1'b0, 32'h0, mis, redir);
        look("sat3_nt1", 32'h100, 1'b1, 32'h80);
        resolve(32'h100, 1'b0, 1'b0, 32'h0, mis, redir);
        look("sat3_nt2", 32'h100, 1'b0, 32'h104);
        resolve(32'h100, 1'b1, 1'b0, 32'h80, mis, redir);

        // Aliasing on index 0
        resolve(32'h140, 1'b1, 1'b0, 32'h200, mis, redir);
        look("alias_old", 32'h100, 1'b0, 32'h104);
        look("alias_new", 32'h140, 1'b1, 32'h200);
        resolve(32'h180, 1'b0, 1'b0, 32'h0, mis, redir);
        look("alias_nt_miss", 32'h140, 1'b1, 32'h200);

        // jal installs taken immediately; jalr with changed target
        resolve(32'h20, 1'b1, 1'b1, 32'h400, mis, redir);
        look("jal", 32'h20, 1'b1, 32'h400);
        resolve(32'h20, 1'b1, 1'b1, 32'h500, mis, redir);
        check("jalr_mispredict", mis, 1'b1);
        check("jalr_redirect",   redir, 32'h500);
        look("jalr_retarget", 32'h20, 1'b1, 32'h500);

        // Flush with a same-cycle update: write dropped, stats counted
        bc_before = m_branch;
        cycle(32'h20, 1'b1, 32'h140, 1'b1, 1'b0, 32'h300, 1'b1, 32'h200, 1'b1, mis, redir);
        look("flush_a", 32'h20,  1'b0, 32'h24);
        look("flush_b", 32'h140, 1'b0, 32'h144);
        check("flush_branch_cnt", bus.BranchCount, bc_before + 1);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            logic [31:0] pce, pcf, tgt, pp;
            bit          upd, taken, jump, pt, flush;
            pce   = $urandom_range(0, 63) * 4;
            pcf   = ($urandom_range(0, 3) == 0) ? pce : $urandom_range(0, 63) * 4;
            upd   = ($urandom_range(0, 3) != 0);
            jump  = ($urandom_range(0, 4) == 0);
            taken = jump ? 1'b1 : 1'($urandom_range(0, 1));
            tgt   = 32'h1000 + $urandom_range(0, 7) * 32'h40;
            flush = ($urandom_range(0, 40) == 0);
            model_predict(pce, pt, pp);
            if ($urandom_range(0, 5) == 0) pt = ~pt;
            cycle(pcf, upd, pce, taken, jump, tgt, pt, pp, flush, mis, redir);

            if (n == 250) begin
                // Asynchronous reset between clock edges
                check("pre_reset_cnt_sat", bus.BranchCount, CNT_MAX);
                bus.UpdateE = 1'b0; bus.FlushAll = 1'b0; bus.PCF = 32'h20;
                #2 reset = 1'b1;
                #1;
                model_reset();
                check("async_branch_cnt",  bus.BranchCount,  0);
                check("async_mispred_cnt", bus.MispredCount, 0);
                check("async_pred_taken",  bus.PredTakenF,   1'b0);
                check("async_pred_pc",     bus.PredPCF,      32'h24);
                @(negedge clk);
                reset = 1'b0;
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
